// File: rtl/fibo_bcd_if.sv
// Handshake bundle between the Fibonacci calculator, the BCD converter and the display stage.
// master: upstream/consumer side (drives start, value_in, bcd_ready).
// slave:  converter side (drives busy, bcd_valid, bcd_out).
interface fibo_bcd_if #(
  parameter int unsigned IN_WIDTH = 16,
  parameter int unsigned DIGITS   = 5
);
  logic                  start;
  logic [IN_WIDTH-1:0]   value_in;
  logic                  busy;
  logic                  bcd_valid;
  logic                  bcd_ready;
  logic [DIGITS*4-1:0]   bcd_out;

  modport master (
    output start, value_in, bcd_ready,
    input  busy, bcd_valid, bcd_out
  );

  modport slave (
    input  start, value_in, bcd_ready,
    output busy, bcd_valid, bcd_out
  );
endinterface

// File: rtl/fibo_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with a valid/ready output handshake that holds the digits until accepted.
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading zero digits shown as 4'hF).
module fibo_bcd_converter #(
  parameter int unsigned IN_WIDTH = 16,
  parameter int unsigned DIGITS   = 5
) (
  input  logic         clk,
  input  logic         reset,
  fibo_bcd_if.slave    bus
);

  localparam int unsigned BCD_W = DIGITS * 4;
  localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t              state_q, state_d;
  logic [IN_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [BCD_W-1:0]    out_q, out_d;
  logic [BCD_W-1:0]    acc_adj;
  logic [BCD_W-1:0]    acc_shift;

  // Add 3 to every digit >= 5; 4-bit wrap, no carry between digits.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] r;
    r = acc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Final presentation of the digits; digit 0 is never blanked.
  function automatic logic [BCD_W-1:0] fmt(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] r;
    r = acc;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
        if (lead && (acc[i*4 +: 4] == 4'd0)) r[i*4 +: 4] = 4'hF;
        else                                 lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  assign acc_adj   = add3(acc_q);
  assign acc_shift = {acc_adj[BCD_W-2:0], bin_q[IN_WIDTH-1]};

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  // Next-state, datapath step and registered-output next values.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d   = bus.value_in;
          acc_d   = '0;
          cnt_d   = CNT_W'(IN_WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_shift;
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out_d   = fmt(acc_shift);
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.bcd_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.busy      = busy_q;
  assign bus.bcd_valid = valid_q;
  assign bus.bcd_out   = out_q;

endmodule

// File: tb/tb_fibo_bcd_converter.sv
// Randomized self-checking bench for fibo_bcd_converter against a decimal-arithmetic model.
module tb_fibo_bcd_converter;

  localparam int unsigned IN_WIDTH = 16;
  localparam int unsigned DIGITS   = 5;

  logic clk;
  logic reset;
  int unsigned checks;
  int unsigned errors;

  fibo_bcd_if #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) bus ();

  fibo_bcd_converter #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Decimal digits by division; blank zero digits above the leading digit when enabled.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned p;
    int unsigned msd;
    r   = '0;
    p   = 1;
    msd = 0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'((v / p) % 10);
      if (((v / p) % 10) != 0) msd = i;
      p = p * 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    for (int unsigned i = 1; i < DIGITS; i++) begin
      if (i > msd) r[i*4 +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (bus.busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  // One full conversion with optional back-pressure and ignored start pulses.
  task automatic run_conv(input logic [15:0] v, input int unsigned hold_cycles,
                          input bit glitch, input bit start_at_accept);
    int unsigned n;
    int unsigned extra;
    logic [19:0] exp;
    exp = ref_bcd(32'(v));
    wait_idle();
    bus.value_in  = v;
    bus.start     = 1'b1;
    bus.bcd_ready = (hold_cycles == 0);
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.value_in = 16'($urandom);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.bcd_valid && n < 40) begin
      if (glitch && n == 4) begin
        bus.start    = 1'b1;
        bus.value_in = 16'd55;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    check("latency", 32'(n), 32'd16);
    check("bcd_out", 32'(bus.bcd_out), 32'(exp));
    check("busy_in_hold", 32'(bus.busy), 32'd1);
    for (int unsigned i = 0; i < hold_cycles; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.bcd_valid), 32'd1);
      check("hold_out", 32'(bus.bcd_out), 32'(exp));
    end
    bus.bcd_ready = 1'b1;
    if (start_at_accept) begin
      bus.start    = 1'b1;
      bus.value_in = 16'd55;
    end
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.bcd_ready = 1'b0;
    check("valid_drop", 32'(bus.bcd_valid), 32'd0);
    check("busy_drop", 32'(bus.busy), 32'd0);
    check("out_kept", 32'(bus.bcd_out), 32'(exp));
    if (glitch || start_at_accept) begin
      extra = 0;
      for (int unsigned i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (bus.bcd_valid || bus.busy) extra++;
      end
      check("no_extra_conv", 32'(extra), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.value_in  = '0;
    bus.bcd_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.bcd_valid), 32'd0);
    check("rst_out", 32'(bus.bcd_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_conv(16'd0, 0, 1'b0, 1'b0);
    run_conv(16'd610, 0, 1'b0, 1'b0);
    run_conv(16'd65535, 1, 1'b0, 1'b0);
    run_conv(16'd46368, 0, 1'b0, 1'b0);
    run_conv(16'd987, 0, 1'b1, 1'b0);
    run_conv(16'd1597, 10, 1'b0, 1'b0);
    run_conv(16'd233, 2, 1'b0, 1'b1);

    // Abort a conversion partway through SHIFT.
    wait_idle();
    bus.value_in = 16'd12345;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_valid", 32'(bus.bcd_valid), 32'd0);
    check("abort_out", 32'(bus.bcd_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_stays_idle", 32'(bus.busy), 32'd0);
    run_conv(16'd89, 0, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      run_conv(16'($urandom), $urandom_range(0, 4), 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
